// File: rtl/rv_pkg.sv
// Shared RV32I constants for the execute stage and its ALU.
//   - Major opcodes (instr[6:0])
//   - Branch funct3 codes and the shift-right funct3
//   - ALU operation codes: {instr[30],funct3} for register/immediate ops,
//     plus otherwise-unused codes for the branch comparisons
//   - Execute-stage control state
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_EQ   = 4'b1001;
  localparam logic [3:0] ALU_NEQ  = 4'b1010;
  localparam logic [3:0] ALU_GE   = 4'b1011;
  localparam logic [3:0] ALU_GEU  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_NONE = 4'b1111;  // always yields 0

  typedef enum logic {
    ST_RUN,
    ST_KILL
  } ex_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU.
//   op_i     : ALU operation code (rv_pkg ALU_*)
//   a_i, b_i : operands
//   result_o : result; comparisons return 0/1 in bit 0
module alu
  import rv_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  // NOTE: every output of an always_comb gets a default first so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'b0, a_i < b_i};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      ALU_SRA:  result_o = $signed(a_i) >>> b_i[4:0];
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_EQ:   result_o = {31'b0, a_i == b_i};
      ALU_NEQ:  result_o = {31'b0, a_i != b_i};
      ALU_GE:   result_o = {31'b0, $signed(a_i) >= $signed(b_i)};
      ALU_GEU:  result_o = {31'b0, a_i >= b_i};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage with valid/ready handshake on both sides.
//   id_*       : decoded bundle in (valid/ready, pc, opcode, funct3, alu_op,
//                rs1/rs2 values, immediate, rd)
//   ex_*       : registered result bundle out (valid/ready, result, store
//                data, rd, opcode, funct3, illegal flag)
//   redirect_* : one-cycle taken branch/jump pulse with target PC
//   flush_i    : kills the stage contents, highest priority
// After a taken redirect the next accepted bundle is the wrong-path
// instruction and is swallowed (KILL state).
module ex_stage
  import rv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [31:0] id_pc_i,
  input  logic [6:0]  id_opcode_i,
  input  logic [2:0]  id_funct3_i,
  input  logic [3:0]  id_alu_op_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [31:0] id_imm_i,
  input  logic [4:0]  id_rd_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] ex_result_o,
  output logic [31:0] ex_store_data_o,
  output logic [4:0]  ex_rd_o,
  output logic [6:0]  ex_opcode_o,
  output logic [2:0]  ex_funct3_o,
  output logic        ex_illegal_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        flush_i
);

  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;
  logic        is_legal, is_jump, is_branch, taken;
  logic [4:0]  rd_sel;
  logic [31:0] jalr_sum, target;

  ex_state_e   state_q, state_d;
  logic        transfer, accept;
  logic        ex_valid_q, ex_valid_d, redirect_q, redirect_d;
  logic [31:0] result_q, store_data_q, redirect_pc_q;
  logic [4:0]  rd_q;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic        illegal_q;

  // Operand and operation select per opcode.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = ALU_ADD;
    is_legal  = 1'b1;
    is_jump   = 1'b0;
    is_branch = 1'b0;
    rd_sel    = id_rd_i;
    case (id_opcode_i)
      OP_LUI:   alu_b = id_imm_i;
      OP_AUIPC: begin alu_a = id_pc_i;       alu_b = id_imm_i; end
      OP_JAL,
      OP_JALR:  begin alu_a = id_pc_i;       alu_b = 32'd4; is_jump = 1'b1; end
      OP_LOAD:  begin alu_a = id_rd1_fix(); alu_b = id_imm_i; end
      OP_STORE: begin alu_a = id_rs1_data_i; alu_b = id_imm_i; rd_sel = '0; end
      OP_ALUI: begin
        alu_a  = id_rs1_data_i;
        alu_b  = id_imm_i;
        // instr[30] is part of the immediate except for SRAI/SRLI.
        alu_op = {id_alu_op_i[3] & (id_funct3_i == F3_SR), id_alu_op_i[2:0]};
      end
      OP_ALUR: begin
        alu_a  = id_rs1_data_i;
        alu_b  = id_rs2_data_i;
        alu_op = id_alu_op_i;
      end
      OP_BRANCH: begin
        alu_a     = id_rs1_data_i;
        alu_b     = id_rs2_data_i;
        is_branch = 1'b1;
        rd_sel    = '0;
        case (id_funct3_i)
          F3_BEQ:  alu_op = ALU_EQ;
          F3_BNE:  alu_op = ALU_NEQ;
          F3_BLT:  alu_op = ALU_SLT;
          F3_BGE:  alu_op = ALU_GE;
          F3_BLTU: alu_op = ALU_SLTU;
          F3_BGEU: alu_op = ALU_GEU;
          default: alu_op = ALU_NONE;  // reserved funct3: never taken
        endcase
      end
      default: begin
        is_legal = 1'b0;
        rd_sel   = '0;
      end
    endcase
  end

  function automatic logic [31:0] id_rd1_fix();
    return id_rs1_data_i;
  endfunction

  alu u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res)
  );

  assign taken    = is_jump | (is_branch & alu_res[0]);
  assign jalr_sum = id_rs1_data_i + id_imm_i;
  assign target   = (id_opcode_i == OP_JALR) ? {jalr_sum[31:1], 1'b0}
                                             : id_pc_i + id_imm_i;

  assign id_ready_o = ~ex_valid_q | ex_ready_i;
  assign transfer   = id_valid_i & id_ready_o;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (transfer && taken) state_d = ST_KILL;
        ST_KILL: if (transfer)          state_d = ST_RUN;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Outputs of the control: a bundle is kept only in RUN without flush.
  // A swallowed transfer implies the old bundle drains (id_ready_o was 1),
  // so the ex_ready_i branch also covers it.
  always_comb begin
    accept     = transfer & ~flush_i & (state_q == ST_RUN);
    redirect_d = accept & taken;
    if (flush_i)         ex_valid_d = 1'b0;
    else if (accept)     ex_valid_d = 1'b1;
    else if (ex_ready_i) ex_valid_d = 1'b0;
    else                 ex_valid_d = ex_valid_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_q    <= 1'b0;
      redirect_q    <= 1'b0;
      result_q      <= '0;
      store_data_q  <= '0;
      redirect_pc_q <= '0;
      rd_q          <= '0;
      opcode_q      <= '0;
      funct3_q      <= '0;
      illegal_q     <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      redirect_q <= redirect_d;
      if (accept) begin
        result_q      <= is_legal ? alu_res : 32'd0;
        store_data_q  <= id_rs2_data_i;
        redirect_pc_q <= target;
        rd_q          <= rd_sel;
        opcode_q      <= id_opcode_i;
        funct3_q      <= id_funct3_i;
        illegal_q     <= ~is_legal;
      end
    end
  end

  assign ex_valid_o       = ex_valid_q;
  assign redirect_valid_o = redirect_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign ex_result_o      = result_q;
  assign ex_store_data_o  = store_data_q;
  assign ex_rd_o          = rd_q;
  assign ex_opcode_o      = opcode_q;
  assign ex_funct3_o      = funct3_q;
  assign ex_illegal_o     = illegal_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vectors with hand-computed
// expectations plus a transaction-level reference model compared every
// falling clock edge.
module tb_ex_stage;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
  localparam logic [6:0] BR = 7'h63, LD = 7'h03, ST = 7'h23, ALUI = 7'h13, ALUR = 7'h33;

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        id_valid_i = 1'b0, ex_ready_i = 1'b1, flush_i = 1'b0;
  logic        id_ready_o;
  logic [31:0] id_pc_i = '0, id_rs1_data_i = '0, id_rs2_data_i = '0, id_imm_i = '0;
  logic [6:0]  id_opcode_i = '0;
  logic [2:0]  id_funct3_i = '0;
  logic [3:0]  id_alu_op_i = '0;
  logic [4:0]  id_rd_i = '0;
  logic        ex_valid_o, ex_illegal_o, redirect_valid_o;
  logic [31:0] ex_result_o, ex_store_data_o, redirect_pc_o;
  logic [4:0]  ex_rd_o;
  logic [6:0]  ex_opcode_o;
  logic [2:0]  ex_funct3_o;

  int n_checks = 0;
  int n_errors = 0;

  ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_pc_i(id_pc_i), .id_opcode_i(id_opcode_i), .id_funct3_i(id_funct3_i),
    .id_alu_op_i(id_alu_op_i), .id_rs1_data_i(id_rs1_data_i),
    .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i), .id_rd_i(id_rd_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_result_o(ex_result_o), .ex_store_data_o(ex_store_data_o),
    .ex_rd_o(ex_rd_o), .ex_opcode_o(ex_opcode_o), .ex_funct3_o(ex_funct3_o),
    .ex_illegal_o(ex_illegal_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .flush_i(flush_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  logic        m_valid = 0, m_redir = 0, m_kill = 0, m_ill = 0;
  logic [31:0] m_res = 0, m_sd = 0, m_tgt = 0;
  logic [4:0]  m_rd = 0;
  logic [6:0]  m_op = 0;
  logic [2:0]  m_f3 = 0;

  always @(posedge clk_i or posedge rst_i) begin
    logic xfer, tk, ill;
    logic [31:0] res, tgt;
    logic [4:0]  rd;
    if (rst_i) begin
      m_valid = 0; m_redir = 0; m_kill = 0; m_ill = 0;
      m_res = 0; m_sd = 0; m_tgt = 0; m_rd = 0; m_op = 0; m_f3 = 0;
    end else begin
      xfer = id_valid_i && (!m_valid || ex_ready_i);
      if (flush_i) begin
        m_valid = 0; m_redir = 0; m_kill = 0;
      end else if (xfer && m_kill) begin
        m_valid = 0; m_redir = 0; m_kill = 0;   // wrong-path bundle swallowed
      end else if (xfer) begin
        tk = 0; ill = 0; rd = id_rd_i; tgt = id_pc_i + id_imm_i;
        case (id_opcode_i)
          LUI:   res = id_imm_i;
          AUIPC: res = id_pc_i + id_imm_i;
          JAL:   begin res = id_pc_i + 4; tk = 1; end
          JALR:  begin res = id_pc_i + 4; tk = 1;
                       tgt = (id_rs1_data_i + id_imm_i) & 32'hFFFF_FFFE; end
          ALUI:  res = alu_ref(id_funct3_i, id_funct3_i == 3'd5 && id_alu_op_i[3],
                               id_rs1_data_i, id_imm_i);
          ALUR:  res = alu_ref(id_funct3_i, id_alu_op_i[3], id_rs1_data_i, id_rs2_data_i);
          LD:    res = id_rs1_data_i + id_imm_i;
          ST:    begin res = id_rs1_data_i + id_imm_i; rd = 0; end
          BR: begin
            case (id_funct3_i)
              3'd0: tk = id_rs1_data_i == id_rs2_data_i;
              3'd1: tk = id_rs1_data_i != id_rs2_data_i;
              3'd4: tk = $signed(id_rs1_data_i) <  $signed(id_rs2_data_i);
              3'd5: tk = $signed(id_rs1_data_i) >= $signed(id_rs2_data_i);
              3'd6: tk = id_rs1_data_i <  id_rs2_data_i;
              3'd7: tk = id_rs1_data_i >= id_rs2_data_i;
              default: tk = 0;
            endcase
            res = {31'b0, tk}; rd = 0;
          end
          default: begin res = 0; rd = 0; ill = 1; end
        endcase
        m_valid = 1; m_redir = tk; m_kill = tk;
        m_res = res; m_sd = id_rs2_data_i; m_tgt = tgt; m_rd = rd;
        m_op = id_opcode_i; m_f3 = id_funct3_i; m_ill = ill;
      end else begin
        m_valid = m_valid && !ex_ready_i;
        m_redir = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    check("cmp_id_ready", id_ready_o, !m_valid || ex_ready_i);
    check("cmp_valid", ex_valid_o, m_valid);
    check("cmp_redirect", redirect_valid_o, m_redir);
    if (m_redir) check("cmp_redirect_pc", redirect_pc_o, m_tgt);
    check("cmp_result", ex_result_o, m_res);
    check("cmp_store_data", ex_store_data_o, m_sd);
    check("cmp_rd", ex_rd_o, m_rd);
    check("cmp_opcode", ex_opcode_o, m_op);
    check("cmp_funct3", ex_funct3_o, m_f3);
    check("cmp_illegal", ex_illegal_o, m_ill);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] aop,
                       input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] rd);
    id_valid_i = 1; id_opcode_i = op; id_funct3_i = f3; id_alu_op_i = aop;
    id_pc_i = pc; id_rs1_data_i = rs1; id_rs2_data_i = rs2; id_imm_i = imm; id_rd_i = rd;
  endtask

  initial begin
    step(); step();
    check("rst_valid", ex_valid_o, 0);
    check("rst_result", ex_result_o, 0);
    check("rst_id_ready", id_ready_o, 1);
    rst_i = 0;
    step();

    // SUB 5-7
    drive(ALUR, 3'd0, 4'b1000, 32'h0, 32'd5, 32'd7, 32'h0, 5'd3); step();
    check("sub_valid", ex_valid_o, 1);
    check("sub_result", ex_result_o, 32'hFFFF_FFFE);
    check("sub_rd", ex_rd_o, 3);
    // ADDI with instr[30] set in the immediate: still an add
    drive(ALUI, 3'd0, 4'b1000, 32'h0, 32'd10, 32'd0, 32'h400, 5'd4); step();
    check("addi_bit30", ex_result_o, 32'h40A);
    drive(ALUI, 3'd5, 4'b1101, 32'h0, 32'h8000_0000, 32'd0, 32'h404, 5'd5); step();
    check("srai", ex_result_o, 32'hF800_0000);
    drive(ALUR, 3'd3, 4'b0011, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'h0, 5'd6); step();
    check("sltu", ex_result_o, 1);
    drive(LUI, 3'd0, 4'd0, 32'h500, 32'h7, 32'd0, 32'h1234_5000, 5'd7); step();
    check("lui", ex_result_o, 32'h1234_5000);
    drive(AUIPC, 3'd0, 4'd0, 32'h1000, 32'h7, 32'd0, 32'h2000, 5'd8); step();
    check("auipc", ex_result_o, 32'h3000);
    drive(LD, 3'd2, 4'd0, 32'h0, 32'hFFFF_FFFF, 32'd0, 32'h1, 5'd9); step();
    check("load_wrap", ex_result_o, 0);
    drive(ST, 3'd2, 4'd0, 32'h0, 32'h100, 32'hCAFE, 32'hFFFF_FFFC, 5'd10); step();
    check("store_addr", ex_result_o, 32'hFC);
    check("store_rd", ex_rd_o, 0);
    check("store_data", ex_store_data_o, 32'hCAFE);

    // BLT taken, then wrong-path bundle swallowed
    drive(BR, 3'd4, 4'd0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd11); step();
    check("blt_redirect", redirect_valid_o, 1);
    check("blt_target", redirect_pc_o, 32'h120);
    drive(ALUI, 3'd0, 4'd0, 32'h104, 32'd1, 32'd0, 32'd1, 5'd12); step();
    check("blt_pulse_end", redirect_valid_o, 0);
    check("blt_discard", ex_valid_o, 0);
    // BEQ not taken
    drive(BR, 3'd0, 4'd0, 32'h200, 32'd1, 32'd2, 32'h40, 5'd13); step();
    check("beq_nt_valid", ex_valid_o, 1);
    check("beq_nt_redirect", redirect_valid_o, 0);

    // JAL, KILL persists over idle cycles
    drive(JAL, 3'd0, 4'd0, 32'h200, 32'd0, 32'd0, 32'h10, 5'd1); step();
    check("jal_link", ex_result_o, 32'h204);
    check("jal_target", redirect_pc_o, 32'h210);
    id_valid_i = 0; step(); step();
    drive(ALUI, 3'd0, 4'd0, 32'h204, 32'd1, 32'd0, 32'd2, 5'd2); step();
    check("kill_persist", ex_valid_o, 0);
    drive(ALUI, 3'd0, 4'd0, 32'h210, 32'd1, 32'd0, 32'd3, 5'd2); step();
    check("after_kill", ex_result_o, 4);

    // JALR, then flush in KILL
    drive(JALR, 3'd0, 4'd0, 32'h40, 32'h1001, 32'd0, 32'd2, 5'd1); step();
    check("jalr_link", ex_result_o, 32'h44);
    check("jalr_target", redirect_pc_o, 32'h1002);
    check("jalr_redirect", redirect_valid_o, 1);
    id_valid_i = 0; step();
    flush_i = 1; drive(ALUI, 3'd0, 4'd0, 32'h44, 32'd7, 32'd0, 32'd7, 5'd2); step();
    flush_i = 0;
    check("flush_kill_valid", ex_valid_o, 0);
    drive(ALUI, 3'd0, 4'd0, 32'h1002, 32'd9, 32'd0, 32'd9, 5'd2); step();
    check("flush_to_run", ex_result_o, 18);

    // Stall three cycles, then back-to-back release
    drive(ALUR, 3'd4, 4'b0100, 32'h0, 32'hF0, 32'h0F, 32'h0, 5'd14); step();
    ex_ready_i = 0;
    drive(ALUR, 3'd6, 4'b0110, 32'h0, 32'h100, 32'h001, 32'h0, 5'd15);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_id_ready", id_ready_o, 0);
      check("stall_hold", ex_result_o, 32'hFF);
    end
    ex_ready_i = 1; step();
    check("release_b", ex_result_o, 32'h101);
    drive(ALUR, 3'd7, 4'b0111, 32'h0, 32'hFF, 32'h0F, 32'h0, 5'd16); step();
    check("b2b_valid", ex_valid_o, 1);
    check("b2b_c", ex_result_o, 32'h0F);

    // Flush during a held bundle
    ex_ready_i = 0; flush_i = 1;
    drive(ALUI, 3'd0, 4'd0, 32'h0, 32'd1, 32'd0, 32'd1, 5'd2); step();
    flush_i = 0; ex_ready_i = 1;
    check("flush_held", ex_valid_o, 0);

    // Illegal opcode
    drive(7'h7F, 3'd5, 4'd0, 32'h300, 32'd5, 32'h55, 32'h8, 5'd17); step();
    check("ill_flag", ex_illegal_o, 1);
    check("ill_result", ex_result_o, 0);
    check("ill_rd", ex_rd_o, 0);
    check("ill_redirect", redirect_valid_o, 0);

    // Asynchronous reset in the middle of a stall
    ex_ready_i = 0; step();
    #1 rst_i = 1;
    #1;
    check("arst_valid", ex_valid_o, 0);
    check("arst_illegal", ex_illegal_o, 0);
    check("arst_store", ex_store_data_o, 0);
    check("arst_opcode", ex_opcode_o, 0);
    check("arst_funct3", ex_funct3_o, 0);
    check("arst_rpc", redirect_pc_o, 0);
    check("arst_redirect", redirect_valid_o, 0);
    id_valid_i = 0; ex_ready_i = 1;
    step();
    rst_i = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL run on one clock; reset is asynchronous and active-high.
REQ-002 Ports SHALL be (name direction width meaning):
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- id_valid_i  in  1  decode bundle valid
- id_ready_o  out  1  stage can accept bundle
- id_pc_i  in  32  instruction PC
- id_opcode_i  in  7  RV32I opcode
- id_funct3_i  in  3  funct3
- id_alu_op_i  in  4  {instr[30],funct3} for ALUR/ALUI
- id_rs1_data_i  in  32  rs1 value
- id_rs2_data_i  in  32  rs2 value
- id_imm_i  in  32  sign-extended immediate
- id_rd_i  in  5  destination register
- ex_valid_o  out  1  result bundle valid
- ex_ready_i  in  1  downstream accepts
- ex_result_o  out  32  ALU result / link address / memory address
- ex_store_data_o  out  32  rs2 value for stores
- ex_rd_o  out  5  destination register (0 for BRANCH/STORE)
- ex_opcode_o  out  7  registered opcode
- ex_funct3_o  out  3  registered funct3
- ex_illegal_o  out  1  unknown opcode flag
- redirect_valid_o  out  1  one-cycle taken-branch/jump pulse
- redirect_pc_o  out  32  redirect target
- flush_i  in  1  kill stage contents

Function
REQ-003 id_ready_o SHALL equal ~ex_valid_o | ex_ready_i; transfer occurs when id_valid_i & id_ready_o.
REQ-004 Operand/op select: LUI 0+imm ADD; AUIPC pc+imm ADD; JAL/JALR pc+4 ADD; ALUI rs1,imm with id_alu_op_i (bit3 forced 0 unless funct3=101); ALUR rs1,rs2,id_alu_op_i; LOAD/STORE rs1+imm ADD.
REQ-005 BRANCH SHALL map funct3 000->EQ, 001->NEQ, 100->SLT, 101->GE, 110->SLTU, 111->GEU; bit0 of ALU result is the taken flag.
REQ-006 Targets: BRANCH/JAL pc+imm; JALR (rs1+imm) with bit0 cleared; all mod 2^32, wrap-around ignored.
REQ-007 Unknown opcode SHALL give result 0, rd 0, ex_illegal_o=1, no redirect; bundle still propagates.
REQ-008 Outputs SHALL be registered on transfer: latency exactly one cycle from id transfer to ex_valid_o.
REQ-009 ex_valid_o SHALL clear when ex_ready_i & ~new transfer; ex_valid_o held with all ex_* stable while ~ex_ready_i.
REQ-010 Simultaneous ex_ready_i drain and new transfer SHALL replace the bundle with no bubble.
REQ-011 redirect_valid_o SHALL pulse exactly one cycle, coincident with the first ex_valid_o cycle of a taken branch, JAL or JALR.
REQ-012 FSM RUN/KILL: RUN->KILL on taken redirect transfer; in KILL the next transfer is accepted and discarded (no ex_valid_o, no redirect), then ->RUN; KILL persists with no input until a transfer occurs.
REQ-013 flush_i SHALL have top priority: next cycle ex_valid_o=0, redirect_valid_o=0, state RUN; any same-cycle input is accepted and dropped.

Reset
REQ-014 Reset SHALL force ex_valid_o=0, redirect_valid_o=0, ex_illegal_o=0, all data outputs 0, state RUN, immediately and asynchronously, including mid-stall.

Structure
REQ-015 Opcode, funct3 and ALU_OP constants SHALL live in shared package rv_pkg.
REQ-016 The existing combinational alu module SHALL be instantiated as the single sub-module; target adders stay in ex_stage.

Verification
REQ-017 ALUR SUB rs1=5, rs2=7 -> next cycle ex_result_o=0xFFFFFFFE, ex_valid_o=1.
REQ-018 BLT pc=0x100, rs1=0xFFFFFFFF, rs2=1, imm=0x20 -> redirect_valid_o one cycle, redirect_pc_o=0x120; next transfer discarded.
REQ-019 JALR pc=0x40, rs1=0x1001, imm=2 -> ex_result_o=0x44, redirect_pc_o=0x1002.
REQ-020 ex_ready_i=0 for 3 cycles with id_valid_i=1 -> id_ready_o=0, outputs stable; release -> back-to-back results, no bubble.
REQ-021 flush_i during held bundle and KILL -> ex_valid_o=0 next cycle, state RUN; rst_i mid-stall -> all outputs 0 asynchronously.
REQ-022 Opcode 0x7F -> ex_illegal_o=1, ex_result_o=0, no redirect.
